// File: rtl/y86_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_seq_pkg
// Purpose  : Shared state encoding, opcode constants and phase-bit indices
//            for the y86 phase sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package y86_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } seq_state_e;

    localparam logic [7:0] OP_LOAD  = 8'h8B;
    localparam logic [7:0] OP_STORE = 8'h89;
    localparam logic [7:0] OP_HALT  = 8'hF4;
    localparam logic [1:0] MOD_MEM  = 2'd1;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;
    localparam int PH_W      = 5;

    function automatic logic is_op_mem(input logic [7:0] op, input logic [1:0] md,
                                       input logic [7:0] ref_op);
        return (op == ref_op) && (md == MOD_MEM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : y86_phase_sequencer_if
// Purpose  : Memory bus handshake between the phase sequencer (master) and
//            the memory subsystem (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface y86_phase_sequencer_if;

    logic bus_req;
    logic bus_we;
    logic mem_ready;

    modport master (output bus_req, output bus_we, input mem_ready);
    modport slave  (input bus_req, input bus_we, output mem_ready);

endinterface
`default_nettype wire

// File: rtl/y86_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : y86_wait_timer
// Purpose  : Counts consecutive not-ready cycles of a bus phase and flags the
//            cycle on which the WAIT_MAX-th consecutive wait is observed.
// Revision : 1.0 - initial release
// ============================================================================
module y86_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  clear,
    input  wire  count_en,
    input  wire  ready,
    output logic expired
);

    localparam int              CW   = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || ready) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A ready on the would-be expiring cycle completes the access instead.
    assign expired = count_en && !clear && !ready && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/y86_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : y86_phase_sequencer
// Purpose  : Stall-capable FETCH/DECODE/EXEC/MEM/WB sequencer for the y86
//            sequential datapath with run/step control and bus timeout.
// Config   : Y86_PHASE_SEQ_PERF_EN builds the instruction/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module y86_phase_sequencer
    import y86_seq_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire  [7:0]            opcode,
    input  wire  [1:0]            mod,
    input  wire                   run_en,
    input  wire                   step_req,
    y86_phase_sequencer_if.master bus,
    output logic [PH_W-1:0]       phase_en,
    output logic                  paused,
    output logic                  halted,
    output logic                  bus_timeout,
    output logic [CNT_W-1:0]      instr_count,
    output logic [CNT_W-1:0]      stall_count
);

    seq_state_e state_q, state_d;
    logic       step_q, step_d;

    logic mem_ready;
    logic is_load, is_store, memop, halt_op;
    logic bus_req_c, bus_we_c;
    logic wait_expired;

    assign mem_ready = bus.mem_ready;
    assign is_load   = is_op_mem(opcode, mod, OP_LOAD);
    assign is_store  = is_op_mem(opcode, mod, OP_STORE);
    assign memop     = is_load || is_store;
    assign halt_op   = (opcode == OP_HALT);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (run_en) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b0;
                end else if (step_req) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (mem_ready)         state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_ERR;
            end
            ST_DECODE: state_d = halt_op ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = ST_MEM;
            ST_MEM: begin
                if (!memop || mem_ready) state_d = ST_WB;
                else if (wait_expired)   state_d = ST_ERR;
            end
            ST_WB: begin
                if (run_en && !step_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                    step_d  = 1'b0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Bus-phase enables follow mem_ready in the completing cycle itself.
    always_comb begin
        phase_en  = '0;
        bus_req_c = 1'b0;
        bus_we_c  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus_req_c          = 1'b1;
                phase_en[PH_FETCH] = mem_ready;
            end
            ST_DECODE: phase_en[PH_DECODE] = 1'b1;
            ST_EXEC:   phase_en[PH_EXEC]   = 1'b1;
            ST_MEM: begin
                if (memop) begin
                    bus_req_c        = 1'b1;
                    bus_we_c         = is_store;
                    phase_en[PH_MEM] = mem_ready;
                end else begin
                    phase_en[PH_MEM] = 1'b1;
                end
            end
            ST_WB:   phase_en[PH_WB] = 1'b1;
            default: ;
        endcase
    end

    assign bus.bus_req  = bus_req_c;
    assign bus.bus_we   = bus_we_c;
    assign paused       = (state_q == ST_IDLE);
    assign halted       = (state_q == ST_HALT);
    assign bus_timeout  = (state_q == ST_ERR);

    y86_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!bus_req_c),
        .count_en (bus_req_c),
        .ready    (mem_ready),
        .expired  (wait_expired)
    );

`ifdef Y86_PHASE_SEQ_PERF_EN
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        instr_count_d = instr_count_q + CNT_W'(state_q == ST_WB);
        stall_count_d = stall_count_q + CNT_W'(bus_req_c && !mem_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
`else
    assign instr_count = '0;
    assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y86_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_phase_sequencer
// Purpose  : Directed self-checking bench for y86_phase_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  opcode;
    logic [1:0]  mod;
    logic        run_en;
    logic        step_req;
    logic [4:0]  phase_en;
    logic        paused;
    logic        halted;
    logic        bus_timeout;
    logic [31:0] instr_count;
    logic [31:0] stall_count;

    int vectors     = 0;
    int miscompares = 0;

    y86_phase_sequencer_if bus ();

    y86_phase_sequencer #(
        .WAIT_MAX (15),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mod         (mod),
        .run_en      (run_en),
        .step_req    (step_req),
        .bus         (bus),
        .phase_en    (phase_en),
        .paused      (paused),
        .halted      (halted),
        .bus_timeout (bus_timeout),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {phase_en, bus_req, bus_we, paused, halted, bus_timeout}.
    task automatic expect_out(input string tag, input logic [4:0] ph, input logic breq,
                              input logic bwe, input logic pau, input logic hlt,
                              input logic tmo);
        #2;
        chk(tag, {22'd0, phase_en, bus.bus_req, bus.bus_we, paused, halted, bus_timeout},
                 {22'd0, ph, breq, bwe, pau, hlt, tmo});
    endtask

    task automatic step_instr(input logic [7:0] op, input logic [1:0] md);
        opcode   = op;
        mod      = md;
        step_req = 1'b1;
        next();
        step_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = 8'h01; mod = 2'd0; run_en = 1'b0; step_req = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state
        next();
        expect_out("reset_outputs", 5'b00000, 0, 0, 1, 0, 0);
        chk("reset_instr_count", instr_count, 32'd0);
        chk("reset_stall_count", stall_count, 32'd0);
        next();
        rst = 1'b0; run_en = 1'b1; bus.mem_ready = 1'b1;

        // Zero-wait continuous run, four instructions
        for (int i = 0; i < 20; i++) begin
            next();
            expect_out($sformatf("run_cycle_%0d", i), 5'b00001 << (i % 5),
                       (i % 5) == 0, 0, 0, 0, 0);
        end
        run_en = 1'b0;
        next();
        expect_out("run_stop_idle", 5'b00000, 0, 0, 1, 0, 0);
`ifdef Y86_PHASE_SEQ_PERF_EN
        chk("run_instr_count", instr_count, 32'd4);
        chk("run_stall_count", stall_count, 32'd0);
`endif

        // Load with three wait states in MEM
        step_instr(8'h8B, 2'd1);
        expect_out("load_fetch", 5'b00001, 1, 0, 0, 0, 0);
        next(); expect_out("load_decode", 5'b00010, 0, 0, 0, 0, 0);
        next(); expect_out("load_exec", 5'b00100, 0, 0, 0, 0, 0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next();
            expect_out($sformatf("load_wait_%0d", i), 5'b00000, 1, 0, 0, 0, 0);
        end
        next(); bus.mem_ready = 1'b1;
        expect_out("load_mem_done", 5'b01000, 1, 0, 0, 0, 0);
        next(); expect_out("load_wb", 5'b10000, 0, 0, 0, 0, 0);
        next(); expect_out("load_idle", 5'b00000, 0, 0, 1, 0, 0);
`ifdef Y86_PHASE_SEQ_PERF_EN
        chk("load_instr_count", instr_count, 32'd5);
        chk("load_stall_count", stall_count, 32'd3);
`endif

        // Store with mod=1 writes in MEM only
        step_instr(8'h89, 2'd1);
        expect_out("store_fetch", 5'b00001, 1, 0, 0, 0, 0);
        next(); expect_out("store_decode", 5'b00010, 0, 0, 0, 0, 0);
        next(); expect_out("store_exec", 5'b00100, 0, 0, 0, 0, 0);
        next(); expect_out("store_mem", 5'b01000, 1, 1, 0, 0, 0);
        next(); expect_out("store_wb", 5'b10000, 0, 0, 0, 0, 0);
        next(); expect_out("store_idle", 5'b00000, 0, 0, 1, 0, 0);

        // Same opcode with mod=3 is a register move: no MEM bus access
        step_instr(8'h89, 2'd3);
        next(); next();
        next(); expect_out("store_mod3_mem", 5'b01000, 0, 0, 0, 0, 0);
        next(); expect_out("store_mod3_wb", 5'b10000, 0, 0, 0, 0, 0);
        next(); expect_out("store_mod3_idle", 5'b00000, 0, 0, 1, 0, 0);

        // Single step; a step_req during EXEC is ignored
        step_instr(8'h01, 2'd0);
        expect_out("step_fetch", 5'b00001, 1, 0, 0, 0, 0);
        next(); expect_out("step_decode", 5'b00010, 0, 0, 0, 0, 0);
        next(); step_req = 1'b1;
        expect_out("step_exec", 5'b00100, 0, 0, 0, 0, 0);
        next(); step_req = 1'b0;
        expect_out("step_mem", 5'b01000, 0, 0, 0, 0, 0);
        next(); expect_out("step_wb", 5'b10000, 0, 0, 0, 0, 0);
        next(); expect_out("step_idle", 5'b00000, 0, 0, 1, 0, 0);
        next(); expect_out("step_idle_hold", 5'b00000, 0, 0, 1, 0, 0);
`ifdef Y86_PHASE_SEQ_PERF_EN
        chk("step_instr_count", instr_count, 32'd8);
`endif

        // FETCH ready arrives on the 15th cycle: no timeout
        bus.mem_ready = 1'b0;
        step_instr(8'h01, 2'd0);
        for (int i = 1; i < 15; i++) begin
            if (i != 1) next();
            expect_out($sformatf("fetch_wait_%0d", i), 5'b00000, 1, 0, 0, 0, 0);
        end
        next(); bus.mem_ready = 1'b1;
        expect_out("fetch_ready_at_limit", 5'b00001, 1, 0, 0, 0, 0);
        next(); expect_out("fetch_limit_decode", 5'b00010, 0, 0, 0, 0, 0);
        next(); next(); next();
        next(); expect_out("fetch_limit_idle", 5'b00000, 0, 0, 1, 0, 0);
`ifdef Y86_PHASE_SEQ_PERF_EN
        chk("limit_instr_count", instr_count, 32'd9);
        chk("limit_stall_count", stall_count, 32'd17);
`endif

        // Halt ignores run_en and step_req until reset
        opcode = 8'hF4; run_en = 1'b1;
        next(); expect_out("halt_fetch", 5'b00001, 1, 0, 0, 0, 0);
        next(); expect_out("halt_decode", 5'b00010, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            next();
            step_req = i[0];
            expect_out($sformatf("halt_hold_%0d", i), 5'b00000, 0, 0, 0, 1, 0);
        end
        rst = 1'b1; step_req = 1'b0; run_en = 1'b0;
        next(); expect_out("halt_reset", 5'b00000, 0, 0, 1, 0, 0);
        rst = 1'b0;

        // Fifteen not-ready FETCH cycles raise the sticky timeout
        bus.mem_ready = 1'b0;
        step_instr(8'h01, 2'd0);
        for (int i = 2; i <= 15; i++) next();
        expect_out("timeout_last_wait", 5'b00000, 1, 0, 0, 0, 0);
        next(); expect_out("timeout_raised", 5'b00000, 0, 0, 0, 0, 1);
        run_en = 1'b1; step_req = 1'b1; bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next();
            expect_out($sformatf("timeout_hold_%0d", i), 5'b00000, 0, 0, 0, 0, 1);
        end
        rst = 1'b1; run_en = 1'b0; step_req = 1'b0;
        next(); expect_out("timeout_reset", 5'b00000, 0, 0, 1, 0, 0);
        chk("final_instr_count", instr_count, 32'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
